// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared types and default constants for the CPU run/halt controller and the
// phase-clock divider. The divider period and the controller's CYCLE_LEN
// both come from CPU_CYCLE_LEN, so they cannot drift apart.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_HALT     = 2'd1,
    ST_RUN      = 2'd2,
    ST_STEP     = 2'd3
  } run_state_e;

  localparam int CPU_CYCLE_LEN = 101;
  localparam int BTN_DEBOUNCE  = 1_000_000;

endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// btn_debounce
// Two-flop synchronizer, level debounce and rising-edge pulse for one raw
// board button.
//
// Ports:
//   clk_100M  in   system clock
//   rst       in   synchronous active-high reset
//   btn       in   raw asynchronous button level
//   evt       out  1-tick pulse on a rising edge of the debounced level
module btn_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE = BTN_DEBOUNCE
) (
  input  logic clk_100M,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [1:0]       sync_q;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] stable_cnt;

  // stable_cnt counts consecutive ticks where the synchronized input disagrees
  // with the accepted level; any agreement (a bounce back) restarts it.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      sync_q     <= 2'b00;
      level      <= 1'b0;
      level_d    <= 1'b0;
      stable_cnt <= '0;
      evt        <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      level_d <= level;
      evt     <= level & ~level_d;
      if (sync_q[1] != level) begin
        if (stable_cnt == CNT_W'(DEBOUNCE - 1)) begin
          level      <= sync_q[1];
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + CNT_W'(1);
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Run/halt/single-step controller for the multi-cycle core. Holds the core
// and divider in reset after power-on, then gates the divider/core with
// cpu_en in whole CPU cycles (CYCLE_LEN ticks) so a halt never cuts a cycle
// short.
//
// Ports:
//   clk_100M    in   system clock
//   rst         in   synchronous active-high reset
//   btn_run     in   raw RUN button
//   btn_step    in   raw STEP button
//   halt_in     in   halt request from core (level)
//   cpu_rst_n   out  active-low reset to divider and core
//   cpu_en      out  advance enable for divider/core
//   phase_cnt   out  position within the current CPU cycle
//   cpu_cycles  out  completed CPU cycles since reset
//   running     out  high in RUN
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_RST_HOLD  | counting down RST_HOLD ticks, cpu_rst_n held low
// ST_HALT      | core frozen, phase_cnt parked at 0
// ST_RUN       | free-running; stop_pend ends it at the next cycle boundary
// ST_STEP      | exactly one CPU cycle, then back to HALT
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CYCLE_LEN = CPU_CYCLE_LEN,
  parameter int DEBOUNCE  = BTN_DEBOUNCE,
  parameter int RST_HOLD  = 16,
  parameter bit START_RUN = 1'b0
) (
  input  logic                         clk_100M,
  input  logic                         rst,
  input  logic                         btn_run,
  input  logic                         btn_step,
  input  logic                         halt_in,
  output logic                         cpu_rst_n,
  output logic                         cpu_en,
  output logic [$clog2(CYCLE_LEN)-1:0] phase_cnt,
  output logic [31:0]                  cpu_cycles,
  output logic                         running
);

  localparam int PH_W   = $clog2(CYCLE_LEN);
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  run_state_e        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              stop_pend;
  logic              run_evt;
  logic              step_evt;
  logic              phase_last;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_run (
    .clk_100M (clk_100M),
    .rst      (rst),
    .btn      (btn_run),
    .evt      (run_evt)
  );

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_step (
    .clk_100M (clk_100M),
    .rst      (rst),
    .btn      (btn_step),
    .evt      (step_evt)
  );

  assign phase_last = (phase_cnt == PH_W'(CYCLE_LEN - 1));

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state      <= ST_RST_HOLD;
      hold_cnt   <= HOLD_W'(RST_HOLD - 1);
      cpu_rst_n  <= 1'b0;
      cpu_en     <= 1'b0;
      phase_cnt  <= '0;
      cpu_cycles <= '0;
      running    <= 1'b0;
      stop_pend  <= 1'b0;
    end else begin
      if (cpu_en) begin
        if (phase_last) begin
          phase_cnt  <= '0;
          cpu_cycles <= cpu_cycles + 32'd1;
        end else begin
          phase_cnt <= phase_cnt + PH_W'(1);
        end
      end

      case (state)
        ST_RST_HOLD: begin
          if (hold_cnt == '0) begin
            cpu_rst_n <= 1'b1;
            if (START_RUN) begin
              state   <= ST_RUN;
              cpu_en  <= 1'b1;
              running <= 1'b1;
            end else begin
              state <= ST_HALT;
            end
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        ST_HALT: begin
          // Run beats step on a tie; a run request is refused while the core
          // itself is asking to halt, but stepping is still allowed.
          if (run_evt && !halt_in) begin
            state   <= ST_RUN;
            cpu_en  <= 1'b1;
            running <= 1'b1;
          end else if (step_evt) begin
            state  <= ST_STEP;
            cpu_en <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop_pend && phase_last) begin
            state     <= ST_HALT;
            cpu_en    <= 1'b0;
            running   <= 1'b0;
            stop_pend <= 1'b0;
          end else if (run_evt || halt_in) begin
            stop_pend <= 1'b1;
          end
        end
        ST_STEP: begin
          if (phase_last) begin
            state  <= ST_HALT;
            cpu_en <= 1'b0;
          end
        end
        default: begin
          state   <= ST_HALT;
          cpu_en  <= 1'b0;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

  localparam int CL = 5;
  localparam int DB = 4;
  localparam int RH = 3;

  logic        clk_100M = 1'b0;
  logic        rst      = 1'b1;
  logic        btn_run  = 1'b0;
  logic        btn_step = 1'b0;
  logic        halt_in  = 1'b0;
  logic        cpu_rst_n;
  logic        cpu_en;
  logic [2:0]  phase_cnt;
  logic [31:0] cpu_cycles;
  logic        running;

  cpu_run_ctrl #(
    .CYCLE_LEN (CL),
    .DEBOUNCE  (DB),
    .RST_HOLD  (RH),
    .START_RUN (1'b0)
  ) dut (
    .clk_100M   (clk_100M),
    .rst        (rst),
    .btn_run    (btn_run),
    .btn_step   (btn_step),
    .halt_in    (halt_in),
    .cpu_rst_n  (cpu_rst_n),
    .cpu_en     (cpu_en),
    .phase_cnt  (phase_cnt),
    .cpu_cycles (cpu_cycles),
    .running    (running)
  );

  always #5 clk_100M = ~clk_100M;

  int n_checks = 0;
  int n_pass   = 0;
  int run_hold = 0;
  int step_hold = 0;

  typedef struct {
    logic        rst_d;
    logic        step_d;
    logic        exp_rst_n;
    logic        exp_en;
    logic [2:0]  exp_ph;
    logic [31:0] exp_cyc;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // One clock: inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk_100M);
    @(negedge clk_100M);
    if (run_hold > 0) begin
      run_hold--;
      if (run_hold == 0) btn_run = 1'b0;
    end
    if (step_hold > 0) begin
      step_hold--;
      if (step_hold == 0) btn_step = 1'b0;
    end
  endtask

  task automatic press_run();
    btn_run  = 1'b1;
    run_hold = 5;
  endtask

  task automatic press_step();
    btn_step  = 1'b1;
    step_hold = 5;
  endtask

  task automatic wait_en(output int n);
    n = 0;
    while (!cpu_en && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic count_burst(output int len);
    len = 0;
    while (cpu_en && len < 60) begin
      len++;
      tick();
    end
  endtask

  task automatic set_vec(input int i, input logic r, input logic s, input logic rn,
                         input logic en, input logic [2:0] ph, input logic [31:0] cyc);
    vecs[i].rst_d     = r;
    vecs[i].step_d    = s;
    vecs[i].exp_rst_n = rn;
    vecs[i].exp_en    = en;
    vecs[i].exp_ph    = ph;
    vecs[i].exp_cyc   = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, len, rest, evt_cnt, evt_i, en_i, en_cnt, base;
    bit forced;

    // Reset release and one clean step press, one row per tick.
    for (int i = 0; i < 18; i++) set_vec(i, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0);
    for (int i = 0; i < 3; i++)  set_vec(i, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    for (int i = 3; i < 7; i++)  set_vec(i, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 32'd0);
    for (int i = 11; i < 16; i++) set_vec(i, 1'b0, 1'b0, 1'b1, 1'b1, 3'(i - 11), 32'd0);
    set_vec(16, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'd1);
    set_vec(17, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'd1);

    repeat (3) @(posedge clk_100M);
    @(negedge clk_100M);
    for (int i = 0; i < 18; i++) begin
      check($sformatf("vec%0d cpu_rst_n", i), cpu_rst_n, vecs[i].exp_rst_n);
      check($sformatf("vec%0d cpu_en", i), cpu_en, vecs[i].exp_en);
      check($sformatf("vec%0d phase_cnt", i), phase_cnt, vecs[i].exp_ph);
      check($sformatf("vec%0d cpu_cycles", i), cpu_cycles, vecs[i].exp_cyc);
      check($sformatf("vec%0d running", i), running, 0);
      rst      = vecs[i].rst_d;
      btn_step = vecs[i].step_d;
      tick();
    end

    // Step with a second step event injected mid-STEP: must not extend it.
    repeat (10) tick();
    press_step();
    wait_en(n);
    check("step2 latency", n, 8);
    len = 0;
    forced = 1'b0;
    while (cpu_en && len < 60) begin
      check($sformatf("step2 phase%0d", len), phase_cnt, len);
      len++;
      if (phase_cnt == 3'd2 && !forced) begin
        force dut.step_evt = 1'b1;
        forced = 1'b1;
        tick();
        release dut.step_evt;
      end else begin
        tick();
      end
    end
    check("step2 burst len", len, 5);
    check("step2 cycles", cpu_cycles, 2);
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (cpu_en) en_cnt++;
      tick();
    end
    check("step2 no extra burst", en_cnt, 0);

    // Bouncing step button: toggles every 2 ticks, then settles high.
    evt_cnt = 0;
    for (int t = 0; t < 20; t++) begin
      if (t % 2 == 0) btn_step = ~btn_step;
      tick();
      if (dut.step_evt) evt_cnt++;
    end
    check("bounce no early evt", evt_cnt, 0);
    btn_step  = 1'b1;
    step_hold = 6;
    evt_i = 0;
    en_i  = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dut.step_evt) begin
        evt_cnt++;
        evt_i = i;
      end
      if (cpu_en && en_i == 0) en_i = i;
    end
    check("bounce evt count", evt_cnt, 1);
    check("bounce evt latency", evt_i, 7);
    check("bounce en latency", en_i, 8);
    check("bounce cycles", cpu_cycles, 3);

    // Run, then a second run press that lands at phase 2 of the third cycle.
    repeat (15) tick();
    base = int'(cpu_cycles);
    press_run();
    wait_en(n);
    check("run latency", n, 8);
    check("run running", running, 1);
    en_cnt = 0;
    while (cpu_en && en_cnt < 100) begin
      en_cnt++;
      if (en_cnt == 6) press_run();
      if (en_cnt == 13) check("run stop phase", phase_cnt, 2);
      tick();
    end
    check("run enabled ticks", en_cnt, 15);
    check("run cycles", cpu_cycles, base + 3);
    check("run halted", running, 0);
    check("run phase parked", phase_cnt, 0);

    // halt_in pulse at phase 0 stops at the end of that cycle.
    repeat (15) tick();
    press_run();
    wait_en(n);
    check("halt_in start phase", phase_cnt, 0);
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0;
    count_burst(rest);
    check("halt_in burst len", 1 + rest, 5);
    check("halt_in cycles", cpu_cycles, 7);

    // Run press refused while halt_in is high; step still works.
    halt_in = 1'b1;
    repeat (15) tick();
    press_run();
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_en) en_cnt++;
    end
    check("run ignored under halt_in", en_cnt, 0);
    check("not running under halt_in", running, 0);
    press_step();
    wait_en(n);
    count_burst(len);
    check("step under halt_in len", len, 5);
    check("step under halt_in cycles", cpu_cycles, 8);
    halt_in = 1'b0;

    // Simultaneous run and step: run wins, nothing pending.
    repeat (15) tick();
    press_run();
    press_step();
    wait_en(n);
    check("simul latency", n, 8);
    check("simul running", running, 1);
    check("simul stop_pend", dut.stop_pend, 0);
    repeat (7) tick();
    check("simul still running", running, 1);
    check("simul still enabled", cpu_en, 1);
    n = 0;
    while (phase_cnt != 3'd3 && n < 20) begin
      tick();
      n++;
    end
    check("pre-reset phase", phase_cnt, 3);
    check("pre-reset cycles", cpu_cycles, 9);

    // Reset mid-cycle aborts immediately.
    rst = 1'b1;
    tick();
    check("midrst cpu_en", cpu_en, 0);
    check("midrst phase", phase_cnt, 0);
    check("midrst cycles", cpu_cycles, 0);
    check("midrst cpu_rst_n", cpu_rst_n, 0);
    check("midrst running", running, 0);
    rst = 1'b0;
    repeat (5) tick();
    check("post-reset cpu_rst_n", cpu_rst_n, 1);
    check("post-reset halted", cpu_en, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/halt/single-step controller for the multi-cycle RISC-V core, sitting directly upstream of the phase-clock divider. It debounces the board RUN and STEP buttons and holds the core and divider in reset after power-on. It produces the enable that lets the divider and core advance in whole CPU cycles (one CPU cycle = one full divider period of clk_100M ticks). A halt is never allowed to truncate a CPU cycle mid-phase.

## Interface

Parameters:
- CYCLE_LEN, 101: clk_100M ticks per CPU cycle (one divider period).
- DEBOUNCE, 1_000_000: stable ticks required before a button level is accepted (10 ms).
- RST_HOLD, 16: ticks cpu_rst_n is held low after rst.
- START_RUN, 0: 1 = enter RUN instead of HALT after reset hold.

Ports:
- clk_100M  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- btn_run  in  1  raw RUN button, asynchronous, active-high.
- btn_step  in  1  raw STEP button, asynchronous, active-high.
- halt_in  in  1  synchronous halt request from core (ebreak/trap), level.
- cpu_rst_n  out  1  active-low reset to divider and core.
- cpu_en  out  1  advance enable for divider/core clocking.
- phase_cnt  out  $clog2(CYCLE_LEN)  position within the current CPU cycle.
- cpu_cycles  out  32  completed CPU cycles since reset.
- running  out  1  high in RUN state.

## Operation

- Buttons: 2-FF synchronizer, then debounce. The accepted level updates only after the synchronized level differs from it for DEBOUNCE consecutive ticks; any bounce restarts the count. A rising edge of the accepted level gives a 1-tick event (run_evt, step_evt).
- FSM states: RST_HOLD, HALT, RUN, STEP.
  - RST_HOLD → HALT (or RUN if START_RUN=1) after RST_HOLD ticks. cpu_rst_n rises on the same edge the state leaves RST_HOLD.
  - HALT: run_evt with halt_in=0 → RUN; step_evt → STEP. If both events occur in the same tick, run wins and step is dropped. run_evt while halt_in=1 is ignored.
  - RUN: run_evt or halt_in=1 sets stop_pend. When stop_pend=1 and phase_cnt=CYCLE_LEN-1 → HALT. step_evt is ignored.
  - STEP: at phase_cnt=CYCLE_LEN-1 → HALT. run_evt and step_evt are ignored.
- cpu_en is registered and equals 1 exactly in RUN/STEP.
- phase_cnt increments while cpu_en=1 and wraps from CYCLE_LEN-1 to 0. It is frozen (always 0) in HALT.
- cpu_cycles increments on every wrap and wraps naturally at 2^32.
- stop_pend clears on entering HALT.

## Timing

- Reset (rst=1 at an edge) gives, next tick: state RST_HOLD, cpu_rst_n=0, cpu_en=0, phase_cnt=0, cpu_cycles=0, running=0, stop_pend=0, debounce counters 0, accepted levels 0, sync FFs 0.
- rst asserted mid-RUN aborts immediately; the partial CPU cycle is not counted.
- Button latency: raw edge to event pulse = 2 (sync) + DEBOUNCE + 1 ticks.
- Event at tick t: state and cpu_en change at t+1.
- STEP: cpu_en high for exactly CYCLE_LEN consecutive ticks; phase_cnt runs 0..CYCLE_LEN-1; cpu_cycles +1 on the final tick's edge.
- RUN stop: cpu_en falls the tick after phase_cnt=CYCLE_LEN-1, so every enabled burst is a multiple of CYCLE_LEN.
- halt_in and run_evt in the same RUN tick: single stop, same boundary.

## Structure

- Package cpu_ctrl_pkg:
  - state enum (RST_HOLD, HALT, RUN, STEP);
  - default constants CPU_CYCLE_LEN=101, BTN_DEBOUNCE=1_000_000;
  - shared with the divider so the divider's period and CYCLE_LEN come from one constant.
- Sub-module btn_debounce (synchronizer + debounce + edge pulse, parameter DEBOUNCE), instantiated twice.
- FSM and counters stay in cpu_run_ctrl.

## Test plan

Use CYCLE_LEN=5, DEBOUNCE=4, RST_HOLD=3, START_RUN=0.

- Reset release: rst 1→0 → cpu_rst_n=0 for 3 ticks then 1; cpu_en=0, cpu_cycles=0, state HALT.
- Bounce: btn_step toggling every 2 ticks for 20 ticks, then stable high → exactly one step_evt, 7 ticks after the last edge.
- Single step: one clean step press in HALT → cpu_en high exactly 5 ticks, phase_cnt 0,1,2,3,4, cpu_cycles=1, back to HALT. A second press during STEP has no effect.
- Run/stop: run press, let 12 enabled ticks elapse, then run press at phase_cnt=2 → cpu_en continues until phase_cnt=4, total enabled ticks 15, cpu_cycles=3.
- halt_in: pulse halt_in=1 for one tick in RUN at phase_cnt=0 → HALT after phase_cnt=4. A run press while halt_in held high is ignored; a step press still yields a 5-tick burst.
- Simultaneous and reset mid-run: run_evt and step_evt in the same HALT tick → RUN with stop_pend=0. rst asserted at phase_cnt=3 in RUN → next tick cpu_en=0, phase_cnt=0, cpu_cycles=0.
